// File: rtl/axis_power_spectrum.sv
// rtl/axis_power_spectrum.sv - per-bin power re^2+im^2 with frame throttling; HALF_SPECTRUM_EN keeps bins 0..N/2-1 only
module axis_power_spectrum #(
  parameter int AXIS_TDATA_WIDTH_IN  = 32,
  parameter int AXIS_TDATA_WIDTH_OUT = 32,
  parameter int LOG_FFT_LENGTH       = 8,
  parameter int THROTTLE_WIDTH       = 5
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            enable,
  input  logic [THROTTLE_WIDTH-1:0]       log_throttle,
  input  logic [AXIS_TDATA_WIDTH_IN-1:0]  S_AXIS_tdata,
  input  logic                            S_AXIS_tvalid,
  input  logic                            S_AXIS_tlast,
  output logic                            S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH_OUT-1:0] M_AXIS_tdata,
  output logic                            M_AXIS_tvalid,
  output logic                            M_AXIS_tlast,
  input  logic                            M_AXIS_tready,
  output logic                            frame_error
);
  localparam int HW  = AXIS_TDATA_WIDTH_IN / 2;
  localparam int PW  = 2 * HW;
  // Frame counter must hold 2^max_throttle - 1
  localparam int FCW = (1 << THROTTLE_WIDTH) - 1;

  localparam logic [LOG_FFT_LENGTH-1:0] BIN_ZERO = '0;
  localparam logic [LOG_FFT_LENGTH-1:0] BIN_ONE  = {{(LOG_FFT_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [LOG_FFT_LENGTH-1:0] BIN_LAST = '1;
`ifdef HALF_SPECTRUM_EN
  localparam logic [LOG_FFT_LENGTH-1:0] BIN_HALF_LAST = {1'b0, {(LOG_FFT_LENGTH-1){1'b1}}};
`endif
  localparam logic [FCW-1:0] FC_ZERO = '0;
  localparam logic [FCW-1:0] FC_ONE  = {{(FCW-1){1'b0}}, 1'b1};
  localparam logic [FCW:0]   FM_ONE  = {{FCW{1'b0}}, 1'b1};

  logic [LOG_FFT_LENGTH-1:0] bin_cnt;
  logic [FCW-1:0]            frame_cnt;
  logic                      run;
  logic [THROTTLE_WIDTH-1:0] thr_latched;

  logic                      advance;
  logic                      accept;
  logic                      frame_start;
  logic                      at_last_bin;
  logic                      frame_end;
  logic                      run_eff;
  logic [THROTTLE_WIDTH-1:0] thr_eff;
  logic [FCW:0]              frame_max;
  logic                      frame_wrap;
  logic                      bin_kept;
  logic                      keep_beat;
  logic                      last_beat;

  logic                      s1_valid;
  logic                      s1_last;
  logic signed [PW-1:0]      s1_re;
  logic signed [PW-1:0]      s1_im;
  logic                      s2_valid;
  logic                      s2_last;
  logic [PW-1:0]             s2_re_sq;
  logic [PW-1:0]             s2_im_sq;

  // The whole pipeline moves as one; input is taken only when it moves
  assign advance       = !M_AXIS_tvalid || M_AXIS_tready;
  assign S_AXIS_tready = advance;
  assign accept        = S_AXIS_tvalid && advance;

  // Frame boundaries: either the count or tlast ends a frame, whichever comes first
  assign frame_start = (bin_cnt == BIN_ZERO);
  assign at_last_bin = (bin_cnt == BIN_LAST);
  assign frame_end   = at_last_bin || S_AXIS_tlast;

  // On the first beat of a frame the controls being latched already apply
  assign run_eff    = frame_start ? enable : run;
  assign thr_eff    = frame_start ? log_throttle : thr_latched;
  assign frame_max  = (FM_ONE << thr_eff) - FM_ONE;
  assign frame_wrap = ({1'b0, frame_cnt} >= frame_max);

`ifdef HALF_SPECTRUM_EN
  assign bin_kept  = !bin_cnt[LOG_FFT_LENGTH-1];
  assign keep_beat = run_eff && (frame_cnt == FC_ZERO) && bin_kept;
  assign last_beat = keep_beat && (frame_end || (bin_cnt == BIN_HALF_LAST));
`else
  assign bin_kept  = 1'b1;
  assign keep_beat = run_eff && (frame_cnt == FC_ZERO) && bin_kept;
  assign last_beat = keep_beat && frame_end;
`endif

  // Bin/frame bookkeeping, advanced once per accepted input beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bin_cnt     <= BIN_ZERO;
      frame_cnt   <= FC_ZERO;
      run         <= 1'b0;
      thr_latched <= '0;
      frame_error <= 1'b0;
    end else if (accept) begin
      bin_cnt <= frame_end ? BIN_ZERO : bin_cnt + BIN_ONE;
      if (frame_start) begin
        run         <= enable;
        thr_latched <= log_throttle;
      end
      if (frame_end) begin
        frame_cnt <= frame_wrap ? FC_ZERO : frame_cnt + FC_ONE;
      end
      if (S_AXIS_tlast != at_last_bin) begin
        frame_error <= 1'b1;
      end
    end
  end

  // Valid/last flags per stage; dropped beats enter S1 as bubbles
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s2_valid      <= 1'b0;
      s2_last       <= 1'b0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
    end else if (advance) begin
      s1_valid      <= accept && keep_beat;
      s1_last       <= accept && last_beat;
      s2_valid      <= s1_valid;
      s2_last       <= s1_last;
      M_AXIS_tvalid <= s2_valid;
      M_AXIS_tlast  <= s2_last;
    end
  end

  // Datapath: sign-extend the halves, square them, then sum (max 2^31 fits unsigned)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_re        <= '0;
      s1_im        <= '0;
      s2_re_sq     <= '0;
      s2_im_sq     <= '0;
      M_AXIS_tdata <= '0;
    end else if (advance) begin
      s1_re        <= PW'($signed(S_AXIS_tdata[HW-1:0]));
      s1_im        <= PW'($signed(S_AXIS_tdata[PW-1:HW]));
      s2_re_sq     <= s1_re * s1_re;
      s2_im_sq     <= s1_im * s1_im;
      M_AXIS_tdata <= AXIS_TDATA_WIDTH_OUT'(s2_re_sq + s2_im_sq);
    end
  end

endmodule

// File: doc/axis_power_spectrum.md
Name: axis_power_spectrum

Overview:
- Sits directly downstream of the Fourier transform stage and consumes its complex AXI-Stream bins: real part in the low half-word, imaginary part in the high half-word, both signed.
- Computes the power per bin as re² + im² through a 3-stage pipeline.
- Keeps one frame in every 2^log_throttle frames, always on frame boundaries, and marks the last bin of each emitted frame with tlast.
- Feeds the DMA/readout path.

Parameters:
- AXIS_TDATA_WIDTH_IN, 32: input width; re = [15:0], im = [31:16], both signed.
- AXIS_TDATA_WIDTH_OUT, 32: output width; unsigned power.
- LOG_FFT_LENGTH, 8: log2 of bins per frame (N = 256).
- THROTTLE_WIDTH, 5: width of the log_throttle control.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  run control; GPIO bit 0 upstream.
- log_throttle  in  THROTTLE_WIDTH  keep 1 frame in every 2^log_throttle frames.
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH_IN  complex bin.
- S_AXIS_tvalid  in  1  input valid.
- S_AXIS_tlast  in  1  last bin of the FFT frame.
- S_AXIS_tready  out  1  input ready.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH_OUT  bin power.
- M_AXIS_tvalid  out  1  output valid.
- M_AXIS_tlast  out  1  last bin of the emitted frame.
- M_AXIS_tready  in  1  downstream ready.
- frame_error  out  1  sticky; tlast/bin-count mismatch.

Behaviour:
- Clock and reset: single clock aclk; aresetn is asynchronous, active-low.
- Reset values:
  - All pipeline valids, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata: 0.
  - frame_error: 0.
  - bin_cnt, frame_cnt: 0.
  - run: 0.
  - thr_latched: 0.
- Reset mid-frame discards all in-flight data; the next accepted beat is bin 0.

Handshake and stall:
- advance = !M_AXIS_tvalid || M_AXIS_tready.
- S_AXIS_tready = advance.
- All pipeline stages shift only when advance = 1.
- A stall freezes every stage and its valid bit; nothing is lost and nothing is duplicated.
- M_AXIS_tdata and M_AXIS_tlast hold stable while tvalid=1 and tready=0.

Pipeline (latency 3 cycles, accept to M_AXIS_tvalid, with no stall):
- S1: register re and im, plus keep flag, last flag and valid.
- S2: signed products re*re and im*im, each 32 bits.
- S3: unsigned 32-bit sum.
  - Maximum value: (-32768)² × 2 = 2^31, which fits; no saturation or truncation.

Bin and frame tracking (on each accepted beat, S_AXIS_tvalid && S_AXIS_tready):
- bin_cnt increments and wraps from N-1 to 0.
- frame_end = (bin_cnt == N-1) || S_AXIS_tlast.
  - If S_AXIS_tlast arrives with bin_cnt != N-1, or bin_cnt == N-1 arrives without tlast: set frame_error.
  - In either case bin_cnt returns to 0 (resync on tlast or on the count, whichever comes first).
- At frame_end:
  - frame_cnt increments.
  - frame_cnt wraps to 0 when it reaches 2^thr_latched - 1, or immediately when thr_latched = 0.
- At every frame start (bin_cnt == 0 on an accepted beat):
  - run <= enable.
  - thr_latched <= log_throttle.
  - Mid-frame changes to enable or log_throttle never split a frame.

Keep and drop:
- keep = run && (frame_cnt == 0).
  - For the frame-start beat, use the values being latched at that beat.
- Dropped beats are still accepted (tready follows advance) but enter S1 with valid=0.
- Output tlast = keep && (bin index == last emitted bin).

Enable:
- While run = 0, input is consumed and discarded and no output is produced.
- Deasserting enable mid-frame completes the current frame.

Optional Feature:
- Macro: HALF_SPECTRUM_EN.
- Defined:
  - Only bins 0..N/2-1 are kept; bins N/2..N-1 are accepted and dropped.
  - tlast is asserted on bin N/2-1.
  - Frame and error tracking still run over N bins.
- Undefined:
  - All N bins are emitted, with tlast on bin N-1.

Test Plan:
- Basic power, reset release, enable=1, log_throttle=0:
  - Stimulus: bin0 = re 3, im 4; bin1 = re -32768, im -32768.
  - Response: outputs 25 and 2147483648, each 3 cycles after acceptance.
  - Response: 256 outputs per frame, tlast only on the 256th.
- Throttle: log_throttle=2, 8 back-to-back frames.
  - Response: frames 0 and 4 emitted (512 beats, 2 tlasts); frames 1-3 and 5-7 produce no tvalid.
- Backpressure: random M_AXIS_tready at 50% over 1 frame of ramp data (re = k, im = 0).
  - Response: the output sequence is exactly k² for k = 0..255, with no gaps or duplicates.
  - Response: tdata stays stable while stalled, and S_AXIS_tready == advance every cycle.
- Enable timing:
  - Stimulus: deassert enable at bin 100 of an emitted frame.
  - Response: the frame completes through bin 255 with tlast, then no output.
  - Stimulus: reassert enable at bin 50.
  - Response: output resumes at the next bin 0.
- Frame error:
  - Stimulus: S_AXIS_tlast at bin 99.
  - Response: frame_error = 1 and stays 1; the next beat is treated as bin 0; the emitted frame carries tlast at bin 99.
  - Response: the following frame is normal (256 beats).
- Asynchronous reset:
  - Stimulus: assert aresetn=0 mid-frame with the pipeline full.
  - Response: M_AXIS_tvalid and frame_error drop to 0 immediately, without waiting for a clock edge.
  - Response: after release, the first accepted beat is bin 0.
  - Bench also runs with HALF_SPECTRUM_EN defined: 128 outputs per frame, tlast on bin 127.
